// File: rtl/fb_pkg.sv
// Shared types, geometry constants and the pixel format helper for the frame-buffer writer.
package fb_pkg;

  localparam int unsigned   AN     = 24;
  localparam int unsigned   DN     = 16;
  localparam int unsigned   BURST  = 8;
  localparam int unsigned   BW     = $clog2(BURST);
  localparam logic [AN-1:0] BASE   = 24'hfa0000;
  localparam int unsigned   LS     = 800;
  localparam int unsigned   X_OFF  = 272;
  localparam int unsigned   Y_OFF  = 120;
  localparam int unsigned   WIDTH  = 256;
  localparam int unsigned   HEIGHT = 240;

  typedef logic [DN-1:0] rgb565_t;

  typedef enum logic [0:0] {StIdle, StBurst} fbw_state_t;

  function automatic rgb565_t rgb888_to_565(input logic [23:0] rgb);
    return {rgb[23:19], rgb[15:10], rgb[7:3]};
  endfunction

endpackage

// File: rtl/fb_group_buf.sv
// Two-slot ping-pong buffer of BURST-word pixel groups, each with its latched start address.
module fb_group_buf
  import fb_pkg::*;
(
  input  logic          clkSYS,
  input  logic          reset,
  input  logic          wr_en,
  input  rgb565_t       wr_data,
  input  logic [AN-1:0] wr_gaddr,
  input  logic          wr_discard,
  output logic          wr_free,
  output logic          wr_partial,
  input  logic [BW-1:0] rd_idx,
  input  logic          rd_release,
  output logic          rd_valid,
  output rgb565_t       rd_data,
  output logic [AN-1:0] rd_gaddr,
  output logic [1:0]    nxt_valid,
  output logic          nxt_partial
);

  rgb565_t       mem_q [2][BURST];
  logic [AN-1:0] gaddr_q [2];
  logic [1:0]    valid_q, valid_d;
  logic          fill_q, fill_d, drain_q, drain_d;
  logic [BW-1:0] ptr_q, ptr_d, wptr;

  // Release is applied before completion so a slot freed this cycle can be refilled at once.
  always_comb begin
    wptr    = wr_discard ? '0 : ptr_q;
    valid_d = valid_q;
    fill_d  = fill_q;
    drain_d = drain_q;
    ptr_d   = wptr;
    if (rd_release) begin
      valid_d[drain_q] = 1'b0;
      drain_d          = ~drain_q;
    end
    if (wr_en) begin
      ptr_d = wptr + BW'(1);
      if (wptr == BW'(BURST - 1)) begin
        valid_d[fill_q] = 1'b1;
        fill_d          = ~fill_q;
      end
    end
  end

  assign wr_free     = !valid_q[fill_q] || (rd_release && (drain_q == fill_q));
  assign wr_partial  = (ptr_q != '0);
  assign rd_valid    = valid_q[drain_q];
  assign rd_data     = mem_q[drain_q][rd_idx];
  assign rd_gaddr    = gaddr_q[drain_q];
  assign nxt_valid   = valid_d;
  assign nxt_partial = (ptr_d != '0);

  always_ff @(posedge clkSYS) begin
    if (reset) begin
      valid_q <= '0;
      fill_q  <= 1'b0;
      drain_q <= 1'b0;
      ptr_q   <= '0;
    end else begin
      valid_q <= valid_d;
      fill_q  <= fill_d;
      drain_q <= drain_d;
      ptr_q   <= ptr_d;
    end
  end

  always_ff @(posedge clkSYS) begin
    if (wr_en) begin
      mem_q[fill_q][wptr] <= wr_data;
      if (wptr == '0) gaddr_q[fill_q] <= wr_gaddr;
    end
  end

endmodule

// File: rtl/fb_writer.sv
// PPU pixel stream to RGB565 frame-buffer writer: positions pixels, packs groups and
// drains each group to the SDRAM arbiter as one write burst.
module fb_writer
  import fb_pkg::*;
(
  input  logic          clkSYS,
  input  logic          reset,
  input  logic          pix_valid,
  input  logic [23:0]   pix_rgb,
  input  logic          pix_sof,
  input  logic          pix_sol,
  output logic [AN-1:0] req_addr,
  output logic [DN-1:0] req_data,
  output logic          req_wr,
  output logic          req,
  input  logic          req_ack,
  output logic          empty,
  output logic          full,
  output logic          overflow
);

  fbw_state_t    state_q, state_d;
  logic [BW-1:0] idx_q, idx_d, rd_idx;
  logic          req_q, req_d;
  logic [AN-1:0] addr_q, addr_d, gaddr, rd_gaddr;
  rgb565_t       data_q, data_d, rd_data, pix565;
  logic [8:0]    x_q, y_q, pos_x, pos_y;
  logic          overflow_q, empty_q, full_q, empty_d, full_d;
  logic          accept, grp_start, can_start, discard, drop, wr_en;
  logic          wr_free, wr_partial, rd_valid, rd_release, nxt_partial;
  logic [1:0]    nxt_valid;

  // Position of the current pixel; counters saturate so far-out pixels never alias back in.
  always_comb begin
    pos_x = x_q;
    pos_y = y_q;
    if (pix_sof) begin
      pos_x = '0;
      pos_y = '0;
    end else if (pix_sol) begin
      pos_x = '0;
      pos_y = (y_q == '1) ? y_q : y_q + 9'd1;
    end
  end

  assign pix565    = rgb888_to_565(pix_rgb);
  assign gaddr     = AN'(32'(BASE) + (32'(pos_y) + Y_OFF) * LS + X_OFF + 32'(pos_x));
  assign accept    = pix_valid && (pos_x < 9'(WIDTH)) && (pos_y < 9'(HEIGHT));
  assign discard   = pix_valid && (pix_sof || pix_sol) && wr_partial;
  assign grp_start = !wr_partial || pix_sof || pix_sol;
  // A group may only open on a burst-aligned column, keeping every burst address aligned.
  assign can_start = wr_free && (pos_x[BW-1:0] == '0);
  assign wr_en     = accept && (!grp_start || can_start);
  assign drop      = accept && grp_start && !can_start;

  fb_group_buf u_buf (
    .clkSYS      (clkSYS),
    .reset       (reset),
    .wr_en       (wr_en),
    .wr_data     (pix565),
    .wr_gaddr    (gaddr),
    .wr_discard  (discard),
    .wr_free     (wr_free),
    .wr_partial  (wr_partial),
    .rd_idx      (rd_idx),
    .rd_release  (rd_release),
    .rd_valid    (rd_valid),
    .rd_data     (rd_data),
    .rd_gaddr    (rd_gaddr),
    .nxt_valid   (nxt_valid),
    .nxt_partial (nxt_partial)
  );

  always_ff @(posedge clkSYS) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (rd_valid) state_d = StBurst;
      StBurst: if (req_ack && (idx_q == BW'(BURST - 1))) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    req_d      = req_q;
    addr_d     = addr_q;
    data_d     = data_q;
    idx_d      = idx_q;
    rd_idx     = idx_q + BW'(1);
    rd_release = 1'b0;
    unique case (state_q)
      StIdle: begin
        rd_idx = '0;
        if (rd_valid) begin
          req_d  = 1'b1;
          addr_d = rd_gaddr;
          data_d = rd_data;
          idx_d  = '0;
        end
      end
      StBurst: begin
        if (req_ack) begin
          if (idx_q == BW'(BURST - 1)) begin
            req_d      = 1'b0;
            rd_release = 1'b1;
          end else begin
            idx_d  = idx_q + BW'(1);
            data_d = rd_data;
          end
        end
      end
      default: ;
    endcase
  end

  assign empty_d = (nxt_valid == 2'b00) && !nxt_partial && (state_d == StIdle);
  assign full_d  = &nxt_valid;

  always_ff @(posedge clkSYS) begin
    if (reset) begin
      idx_q      <= '0;
      req_q      <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      x_q        <= '0;
      y_q        <= '0;
      overflow_q <= 1'b0;
      empty_q    <= 1'b1;
      full_q     <= 1'b0;
    end else begin
      idx_q      <= idx_d;
      req_q      <= req_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      overflow_q <= overflow_q | drop | discard;
      empty_q    <= empty_d;
      full_q     <= full_d;
      if (pix_valid) begin
        x_q <= (pos_x == '1) ? pos_x : pos_x + 9'd1;
        y_q <= pos_y;
      end
    end
  end

  assign req      = req_q;
  assign req_wr   = req_q;
  assign req_addr = addr_q;
  assign req_data = data_q;
  assign empty    = empty_q;
  assign full     = full_q;
  assign overflow = overflow_q;

endmodule
